// File: rtl/rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux4_arbiter
// Description : Four-requester round-robin arbiter driving a shared 4:1 data
//               mux. An owner may keep the grant for up to MAX_BURST
//               consecutive cycles while others are waiting. A lone
//               requester keeps the grant indefinitely. Handover to the next
//               requester happens on a single edge with no idle bubble.
// Ports       : clk          - rising-edge clock
//               rst          - asynchronous active-high reset
//               req[3:0]     - request vector, bit i requests data path d<i>
//               d0..d3       - WIDTH-bit data sources
//               gnt[3:0]     - registered one-hot grant (zero when no owner)
//               s1, s0       - registered select, index of current/last owner
//               valid        - registered, high while an owner holds the grant
//               y            - d<{s1,s0}> when valid, otherwise zero
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux4_arbiter #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic             valid,
  output logic [WIDTH-1:0] y
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

  // Registered state
  logic [0:0] r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_valid;
  logic [1:0] r_last;
  logic [7:0] r_cnt;

  // Next-state values
  logic [0:0] w_state;
  logic [3:0] w_gnt;
  logic [1:0] w_sel;
  logic       w_valid;
  logic [1:0] w_last;
  logic [7:0] w_cnt;

  // Round-robin search helpers
  logic [1:0] w_win;
  logic       w_found;
  logic [1:0] w_idx;
  logic [3:0] w_owner_oh;
  logic       w_owner_req;
  logic       w_other_req;
  logic [7:0] w_cnt_inc;

  // Search begins just after the last owner. The fourth step lands on the
  // last owner itself, so a former owner is only chosen when nobody else
  // is requesting.
  always_comb begin
    w_win   = 2'd0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // While BUSY, r_last always names the current owner.
  assign w_owner_oh  = 4'b0001 << r_last;
  assign w_owner_req = |(req & w_owner_oh);
  assign w_other_req = |(req & ~w_owner_oh);
  assign w_cnt_inc   = (r_cnt < c_max_burst) ? (r_cnt + 8'd1) : r_cnt;

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 2'd3;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_sel   <= w_sel;
      r_valid <= w_valid;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_sel   = r_sel;
    w_valid = r_valid;
    w_last  = r_last;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state = S_BUSY;
          w_gnt   = 4'b0001 << w_win;
          w_sel   = w_win;
          w_valid = 1'b1;
          w_last  = w_win;
          w_cnt   = 8'd1;
        end else begin
          w_gnt   = 4'b0000;
          w_valid = 1'b0;
        end
      end
      S_BUSY: begin
        if (!w_found) begin
          // Nobody requesting: release, select keeps the last owner.
          w_state = S_IDLE;
          w_gnt   = 4'b0000;
          w_valid = 1'b0;
        end else if (w_owner_req && ((r_cnt < c_max_burst) || !w_other_req)) begin
          // Owner keeps the grant; counter saturates at the burst limit.
          w_cnt = w_cnt_inc;
        end else begin
          // Burst exhausted or owner released: hand over on this edge.
          w_gnt   = 4'b0001 << w_win;
          w_sel   = w_win;
          w_valid = 1'b1;
          w_last  = w_win;
          w_cnt   = 8'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_gnt   = 4'b0000;
        w_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    y = '0;
    if (r_valid) begin
      case (r_sel)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign s1    = r_sel[1];
  assign s0    = r_sel[0];
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux4_arbiter
// Description : Directed self-checking bench for rr_mux4_arbiter. Expected
//               grant/select/valid values are queued when a request pattern
//               is driven and compared after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux4_arbiter;

  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       gnt;
  logic             s1, s0, valid;
  logic [WIDTH-1:0] y;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  rr_mux4_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .s1(s1), .s0(s0), .valid(valid), .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_y(input logic v, input logic [1:0] s);
    if (!v) return '0;
    case (s)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

  // Drive req now (just after an edge), queue the expectation, check after
  // the next rising edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                     input logic ev, input string tag);
    exp_t e;
    exp_t p;
    req     = r;
    p.tag   = tag;
    p.gnt   = eg;
    p.sel   = es;
    p.valid = ev;
    sb.push_back(p);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "/gnt"},   32'(gnt),      32'(e.gnt));
    chk({e.tag, "/sel"},   32'({s1, s0}), 32'(e.sel));
    chk({e.tag, "/valid"}, 32'(valid),    32'(e.valid));
    chk({e.tag, "/y"},     32'(y),        32'(exp_y(e.valid, e.sel)));
    chk({e.tag, "/vgnt"},  32'(valid),    32'(|gnt));
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    d0  = 4'hA;
    d1  = 4'h5;
    d2  = 4'hC;
    d3  = 4'h3;

    // Reset with all requesters active
    repeat (2) @(posedge clk);
    #1;
    chk("rst/gnt",   32'(gnt),      32'h0);
    chk("rst/valid", 32'(valid),    32'h0);
    chk("rst/y",     32'(y),        32'h0);
    chk("rst/sel",   32'({s1, s0}), 32'h0);
    rst = 1'b0;

    // Fairness: 0,1,2,3,0 each held 4 cycles, first grant to requester 0
    for (int i = 0; i < 20; i++)
      cyc(4'b1111, 4'(4'b0001 << ((i / 4) % 4)), 2'((i / 4) % 4), 1'b1, "fair");
    cyc(4'b0000, 4'b0000, 2'd0, 1'b0, "fair_idle");

    // Select mapping, each requester alone
    d0 = 4'h1; d1 = 4'h0; d2 = 4'h1; d3 = 4'h0;
    cyc(4'b0001, 4'b0001, 2'd0, 1'b1, "sel0");
    cyc(4'b0010, 4'b0010, 2'd1, 1'b1, "sel1");
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, "sel2");
    cyc(4'b1000, 4'b1000, 2'd3, 1'b1, "sel3");
    // Data propagates combinationally while valid
    d3 = 4'h7;
    #1;
    chk("comb_y", 32'(y), 32'h7);
    cyc(4'b0000, 4'b0000, 2'd3, 1'b0, "sel_idle");

    // Early release: owner 1 drops after 2 cycles, requester 3 waiting
    d0 = 4'hA; d1 = 4'h5; d2 = 4'hC; d3 = 4'h3;
    cyc(4'b1010, 4'b0010, 2'd1, 1'b1, "early_g1");
    cyc(4'b1010, 4'b0010, 2'd1, 1'b1, "early_h1");
    // Mid-cycle req change must not disturb registered outputs
    req = 4'b0000;
    #2;
    chk("hold_gnt",   32'(gnt),   32'b0010);
    chk("hold_valid", 32'(valid), 32'h1);
    cyc(4'b1000, 4'b1000, 2'd3, 1'b1, "early_g3");
    // Counter restarted: owner 3 keeps 3 more cycles before handing to 1
    for (int i = 0; i < 3; i++)
      cyc(4'b1010, 4'b1000, 2'd3, 1'b1, "early_h3");
    cyc(4'b1010, 4'b0010, 2'd1, 1'b1, "early_rr1");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, "early_idle");

    // Lone owner never dropped at the burst boundary
    for (int i = 0; i < 10; i++)
      cyc(4'b0100, 4'b0100, 2'd2, 1'b1, "lone");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, "lone_idle");

    // Reset mid-burst between edges
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, "mrst_g2");
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, "mrst_h2");
    #2;
    rst = 1'b1;
    #1;
    chk("mrst/gnt",   32'(gnt),      32'h0);
    chk("mrst/valid", 32'(valid),    32'h0);
    chk("mrst/y",     32'(y),        32'h0);
    chk("mrst/sel",   32'({s1, s0}), 32'h0);
    rst = 1'b0;
    cyc(4'b0110, 4'b0010, 2'd1, 1'b1, "mrst_after");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, "final_idle");

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_mux4_arbiter.md
RR_MUX4_ARBITER -- requirements
Module: rr_mux4_arbiter

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data input and of y.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive cycles one owner holds the grant while another requester is pending; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  request vector; bit i requests data path d<i>.
REQ-006 d0, d1, d2, d3  input  WIDTH each  data sources shared through the 4:1 mux.
REQ-007 gnt  output  4  one-hot grant, registered; all zero when no owner.
REQ-008 s1, s0  output  1 each  registered mux select, {s1,s0} = index of current or last owner.
REQ-009 valid  output  1  registered; high while an owner holds the grant.
REQ-010 y  output  WIDTH  mux output: d<{s1,s0}> when valid = 1, else all zero; combinational from registered select and data inputs.

Function
REQ-011 The block SHALL implement two states: IDLE (no owner) and BUSY (owner held).
REQ-012 The block SHALL keep an internal last-owner index (2 bits) and a burst counter (8 bits).
REQ-013 Arbitration SHALL be round-robin: search order starts at last+1 and wraps modulo 4 (for example, last = 3 gives order 0,1,2,3); the first asserted req bit wins.
REQ-014 In IDLE with req != 0, the next edge SHALL go to BUSY with the following updates: gnt = onehot(winner), {s1,s0} = winner, valid = 1, last = winner, counter = 1.
  - Latency is one cycle from req sampled to gnt visible.
REQ-015 In IDLE with req = 0, all state SHALL hold and gnt = 0, valid = 0.
REQ-016 In BUSY, the owner SHALL retain the grant when both of these hold:
  - req[owner] = 1;
  - counter < MAX_BURST, or no other req bit is set.
  - Effect: counter increments, saturating at MAX_BURST.
REQ-017 In BUSY with req[owner] = 1, counter = MAX_BURST and another req bit set, the block SHALL re-arbitrate on the next edge.
  - The winner is chosen round-robin, starting after the owner.
  - The new owner is granted on that same edge with no idle bubble; counter = 1 and last = new owner.
REQ-018 In BUSY with req[owner] = 0 and other requests pending, the block SHALL grant the round-robin winner on the next edge (no bubble), with counter = 1.
REQ-019 In BUSY with req = 0, the block SHALL return to IDLE on the next edge: gnt = 0, valid = 0, {s1,s0} holding the last owner.
REQ-020 When re-arbitration finds only the former owner requesting, the owner SHALL be re-granted with counter = 1.
REQ-021 gnt SHALL never have more than one bit set, and valid SHALL equal |gnt in every cycle.
REQ-022 req changes between edges SHALL have no effect on gnt, s1, s0 or valid until the next rising edge.
REQ-023 Data changes SHALL propagate to y combinationally in the same cycle whenever valid = 1.

Reset
REQ-024 While rst = 1, asynchronously and regardless of clk, the block SHALL hold these values:
  - state = IDLE, gnt = 4'b0000, s1 = 0, s0 = 0;
  - valid = 0, y = 0, last = 3, counter = 0.
REQ-025 Reset asserted mid-burst SHALL drop the grant immediately, with no completion of the current ownership.
REQ-026 After rst deasserts, the first grant SHALL follow REQ-014 from the first rising edge, with priority starting at requester 0.

Verification
REQ-027 Reset/idle: assert rst with req = 4'b1111 -> gnt = 0, valid = 0, y = 0 immediately. Release rst -> gnt = 4'b0001 after the first edge and y = d0.
REQ-028 Select mapping: set d0 = 1, d1 = 0, d2 = 1, d3 = 0 and grant each requester in turn alone -> {s1,s0} = 00, 01, 10, 11 and y = 1, 0, 1, 0.
REQ-029 Fairness: with MAX_BURST = 4 and req = 4'b1111 held for 20 cycles -> grants cycle in the order 0,1,2,3,0, each held exactly 4 cycles, with no bubble cycles.
REQ-030 Early release: owner 1 drops req after 2 cycles while req[3] = 1 -> gnt = 4'b1000 on the next edge, counter restarts, and valid stays high.
REQ-031 Lone owner: req = 4'b0100 held for 10 cycles -> gnt stays 4'b0100 throughout, with no drop at the MAX_BURST boundary. Then req = 0 -> valid = 0 and y = 0 after one edge, with s1,s0 = 10 held.
REQ-032 Reset mid-burst: pulse rst between edges during ownership by requester 2 -> outputs clear without waiting for a clock edge. After release with req = 4'b0110 -> the grant goes to 1, not 2.
